// File: rtl/stage5_writeback_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage5_writeback_lsu_pkg
// Purpose  : Shared types for the writeback/LSU stage. Holds the RISC-V style
//            opcode and load funct3 encodings, the byte width, and the
//            writeback FSM state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stage5_writeback_lsu_pkg;

  localparam int BYTE_WIDTH = 8;

  typedef enum logic [6:0] {
    OP_LOAD      = 7'b0000011,
    OP_ARITH_IMM = 7'b0010011,
    OP_STORE     = 7'b0100011,
    OP_ARITH     = 7'b0110011,
    OP_BRANCH    = 7'b1100011,
    OP_JALR      = 7'b1100111,
    OP_JAL       = 7'b1101111
  } opcode_t;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_funct3_t;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_t;

endpackage : stage5_writeback_lsu_pkg
`default_nettype wire

// File: rtl/stage5_writeback_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : stage5_writeback_lsu_if / stage5_writeback_lsu_rf_if
// Purpose  : Bus bundles of the writeback stage.
//            stage5_writeback_lsu_if    : stage-4 -> stage-5 beat
//              tvalid, tready, opcode, funct3, rd, alu_result, branch_target
//            stage5_writeback_lsu_rf_if : register-file write port
//              enable, address, data
// Revision : 1.0 - initial release
// ============================================================================
interface stage5_writeback_lsu_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDR_WIDTH     = 5
) ();
  logic                      tvalid;
  logic                      tready;
  logic [6:0]                opcode;
  logic [2:0]                funct3;
  logic [ADDR_WIDTH-1:0]     rd;
  logic [REGISTER_WIDTH-1:0] alu_result;
  logic [REGISTER_WIDTH-1:0] branch_target;

  modport master (output tvalid, opcode, funct3, rd, alu_result, branch_target,
                  input  tready);
  modport slave  (input  tvalid, opcode, funct3, rd, alu_result, branch_target,
                  output tready);
endinterface : stage5_writeback_lsu_if

interface stage5_writeback_lsu_rf_if #(
  parameter int REGISTER_WIDTH = 32,
  parameter int ADDR_WIDTH     = 5
) ();
  logic                      enable;
  logic [ADDR_WIDTH-1:0]     address;
  logic [REGISTER_WIDTH-1:0] data;

  modport master (output enable, address, data);
  modport slave  (input  enable, address, data);
endinterface : stage5_writeback_lsu_rf_if
`default_nettype wire

// File: rtl/stage5_writeback_lsu_load_aligner.sv
`default_nettype none
// ============================================================================
// Module   : stage5_writeback_lsu_load_aligner
// Purpose  : Combinational load alignment. Shifts the naturally aligned memory
//            word down by the byte offset, then sign/zero-extends according
//            to funct3, and flags accesses not aligned to their size.
// Ports    : rdata (in, RW)  offset (in, log2(RW/8))  funct3 (in, 3)
//            data (out, RW)  misaligned (out, 1)
// Revision : 1.0 - initial release
// ============================================================================
module stage5_writeback_lsu_load_aligner
  import stage5_writeback_lsu_pkg::*;
#(
  parameter  int REGISTER_WIDTH = 32,
  localparam int OFFSET_WIDTH   = $clog2(REGISTER_WIDTH / BYTE_WIDTH)
) (
  input  wire logic [REGISTER_WIDTH-1:0] rdata,
  input  wire logic [OFFSET_WIDTH-1:0]   offset,
  input  wire logic [2:0]                funct3,
  output logic      [REGISTER_WIDTH-1:0] data,
  output logic                           misaligned
);

  logic [REGISTER_WIDTH-1:0] shifted;

  assign shifted = rdata >> (32'(offset) * BYTE_WIDTH);

  // At RW=32 a word load fills the register, so sign- and zero-extension of
  // the 32-bit slice are both identity; LD there degenerates to a word load.
  always_comb begin
    data       = shifted;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = REGISTER_WIDTH'($signed(shifted[7:0]));
      F3_LBU: data = REGISTER_WIDTH'(shifted[7:0]);
      F3_LH: begin
        data       = REGISTER_WIDTH'($signed(shifted[15:0]));
        misaligned = offset[0];
      end
      F3_LHU: begin
        data       = REGISTER_WIDTH'(shifted[15:0]);
        misaligned = offset[0];
      end
      F3_LW: begin
        data       = REGISTER_WIDTH'($signed(shifted[31:0]));
        misaligned = |offset[1:0];
      end
      F3_LWU: begin
        data       = REGISTER_WIDTH'(shifted[31:0]);
        misaligned = |offset[1:0];
      end
      F3_LD: begin
        data       = shifted;
        misaligned = |offset;
      end
      default: data = shifted;
    endcase
  end

endmodule : stage5_writeback_lsu_load_aligner
`default_nettype wire

// File: rtl/stage5_writeback_lsu.sv
`default_nettype none
// ============================================================================
// Module   : stage5_writeback_lsu
// Purpose  : Writeback stage after stage 4. Registers a 1-cycle retire onto
//            the register-file write port, waits for variable-latency load
//            data with a timeout, aligns loads, flags misaligned loads,
//            supports flush and counts retired instructions.
// Ports    : clk, rst (async, active-low)
//            axis_memory_to_writeback (slave beat), flush
//            mem_rvalid, mem_rdata (RW)
//            registerport_write (write port), wb_valid/wb_rd/wb_data bypass
//            misaligned_load, load_timeout (pulses), instret (64)
// Revision : 1.0 - initial release
// ============================================================================
module stage5_writeback_lsu
  import stage5_writeback_lsu_pkg::*;
#(
  parameter  int REGISTER_WIDTH = 32,
  parameter  int REGISTER_DEPTH = 32,
  parameter  int LOAD_TIMEOUT   = 16,
  localparam int ADDR_WIDTH     = $clog2(REGISTER_DEPTH)
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  stage5_writeback_lsu_if.slave          axis_memory_to_writeback,
  input  wire logic                      flush,
  input  wire logic                      mem_rvalid,
  input  wire logic [REGISTER_WIDTH-1:0] mem_rdata,
  stage5_writeback_lsu_rf_if.master      registerport_write,
  output logic                           wb_valid,
  output logic      [ADDR_WIDTH-1:0]     wb_rd,
  output logic      [REGISTER_WIDTH-1:0] wb_data,
  output logic                           misaligned_load,
  output logic                           load_timeout,
  output logic      [63:0]               instret
);

  localparam int OFFSET_WIDTH = $clog2(REGISTER_WIDTH / BYTE_WIDTH);
  localparam int CNT_WIDTH    = $clog2(LOAD_TIMEOUT + 1);

  wb_state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]     pend_rd_q, pend_rd_d;
  logic [2:0]                pend_funct3_q, pend_funct3_d;
  logic [OFFSET_WIDTH-1:0]   pend_offset_q, pend_offset_d;
  logic                      we_q, we_d;
  logic [ADDR_WIDTH-1:0]     rd_q, rd_d;
  logic [REGISTER_WIDTH-1:0] data_q, data_d;
  logic                      mis_q, mis_d;
  logic                      to_q, to_d;
  logic [63:0]               instret_q, instret_d;

  logic                      in_wait;
  logic                      accept;
  logic [2:0]                al_funct3;
  logic [OFFSET_WIDTH-1:0]   al_offset;
  logic [REGISTER_WIDTH-1:0] al_data;
  logic                      al_mis;
  logic                      complete;
  logic                      cpl_writes;
  logic [ADDR_WIDTH-1:0]     cpl_rd;
  logic [REGISTER_WIDTH-1:0] cpl_data;

  assign in_wait = (state_q == WAIT_LOAD);
  assign axis_memory_to_writeback.tready = !in_wait;
  assign accept  = axis_memory_to_writeback.tvalid && !in_wait;

  // One aligner serves both paths: the live beat in IDLE, the captured
  // load attributes while waiting for the response.
  assign al_funct3 = in_wait ? pend_funct3_q : axis_memory_to_writeback.funct3;
  assign al_offset = in_wait ? pend_offset_q
                             : axis_memory_to_writeback.alu_result[OFFSET_WIDTH-1:0];

  stage5_writeback_lsu_load_aligner #(
    .REGISTER_WIDTH(REGISTER_WIDTH)
  ) u_load_aligner (
    .rdata      (mem_rdata),
    .offset     (al_offset),
    .funct3     (al_funct3),
    .data       (al_data),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_rd_d     = pend_rd_q;
    pend_funct3_d = pend_funct3_q;
    pend_offset_d = pend_offset_q;
    we_d          = 1'b0;
    rd_d          = '0;
    data_d        = '0;
    mis_d         = 1'b0;
    to_d          = 1'b0;
    instret_d     = instret_q;
    complete      = 1'b0;
    cpl_writes    = 1'b0;
    cpl_rd        = '0;
    cpl_data      = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (axis_memory_to_writeback.opcode == OP_LOAD) begin
            if (al_mis) begin
              mis_d = 1'b1;
            end else if (mem_rvalid) begin
              complete   = 1'b1;
              cpl_writes = 1'b1;
              cpl_rd     = axis_memory_to_writeback.rd;
              cpl_data   = al_data;
            end else begin
              state_d       = WAIT_LOAD;
              pend_rd_d     = axis_memory_to_writeback.rd;
              pend_funct3_d = axis_memory_to_writeback.funct3;
              pend_offset_d = axis_memory_to_writeback.alu_result[OFFSET_WIDTH-1:0];
            end
          end else begin
            // Non-writing opcodes (store, branch, ...) still retire.
            complete = 1'b1;
            cpl_rd   = axis_memory_to_writeback.rd;
            case (axis_memory_to_writeback.opcode)
              OP_ARITH, OP_ARITH_IMM, OP_JALR: begin
                cpl_writes = 1'b1;
                cpl_data   = axis_memory_to_writeback.alu_result;
              end
              OP_JAL: begin
                cpl_writes = 1'b1;
                cpl_data   = axis_memory_to_writeback.branch_target;
              end
              default: cpl_writes = 1'b0;
            endcase
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          complete   = 1'b1;
          cpl_writes = 1'b1;
          cpl_rd     = pend_rd_q;
          cpl_data   = al_data;
          state_d    = IDLE;
          cnt_d      = '0;
        end else if (cnt_q == CNT_WIDTH'(LOAD_TIMEOUT - 1)) begin
          // Last permitted wait cycle has passed without a response.
          to_d    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush beats response and timeout, and swallows an accepted beat.
    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      complete = 1'b0;
      mis_d    = 1'b0;
      to_d     = 1'b0;
    end

    if (complete) begin
      instret_d = instret_q + 64'd1;
      if (cpl_writes && (cpl_rd != '0)) begin
        we_d   = 1'b1;
        rd_d   = cpl_rd;
        data_d = cpl_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pend_rd_q     <= '0;
      pend_funct3_q <= '0;
      pend_offset_q <= '0;
      we_q          <= 1'b0;
      rd_q          <= '0;
      data_q        <= '0;
      mis_q         <= 1'b0;
      to_q          <= 1'b0;
      instret_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_rd_q     <= pend_rd_d;
      pend_funct3_q <= pend_funct3_d;
      pend_offset_q <= pend_offset_d;
      we_q          <= we_d;
      rd_q          <= rd_d;
      data_q        <= data_d;
      mis_q         <= mis_d;
      to_q          <= to_d;
      instret_q     <= instret_d;
    end
  end

  assign registerport_write.enable  = we_q;
  assign registerport_write.address = rd_q;
  assign registerport_write.data    = data_q;
  assign wb_valid        = we_q;
  assign wb_rd           = rd_q;
  assign wb_data         = data_q;
  assign misaligned_load = mis_q;
  assign load_timeout    = to_q;
  assign instret         = instret_q;

endmodule : stage5_writeback_lsu
`default_nettype wire

// File: tb/tb_stage5_writeback_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage5_writeback_lsu
// Purpose  : Self-checking bench for stage5_writeback_lsu. Drives a 32-bit
//            and a 64-bit instance with directed and random instructions and
//            compares against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage5_writeback_lsu;
  import stage5_writeback_lsu_pkg::*;

  localparam int TO = 16;

  logic        clk;
  logic        rst32, rst64, fl32, fl64, rv32, rv64;
  logic [31:0] rdat32;
  logic [63:0] rdat64;
  logic        wbv32, wbv64, mis32, mis64, to32, to64;
  logic [4:0]  wbr32, wbr64;
  logic [31:0] wbd32;
  logic [63:0] wbd64, ir32, ir64;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] icnt [2];

  stage5_writeback_lsu_if    #(.REGISTER_WIDTH(32), .ADDR_WIDTH(5)) ax32 ();
  stage5_writeback_lsu_rf_if #(.REGISTER_WIDTH(32), .ADDR_WIDTH(5)) rf32 ();
  stage5_writeback_lsu_if    #(.REGISTER_WIDTH(64), .ADDR_WIDTH(5)) ax64 ();
  stage5_writeback_lsu_rf_if #(.REGISTER_WIDTH(64), .ADDR_WIDTH(5)) rf64 ();

  stage5_writeback_lsu #(.REGISTER_WIDTH(32), .REGISTER_DEPTH(32), .LOAD_TIMEOUT(TO)) dut32 (
    .clk(clk), .rst(rst32), .axis_memory_to_writeback(ax32), .flush(fl32),
    .mem_rvalid(rv32), .mem_rdata(rdat32), .registerport_write(rf32),
    .wb_valid(wbv32), .wb_rd(wbr32), .wb_data(wbd32),
    .misaligned_load(mis32), .load_timeout(to32), .instret(ir32));

  stage5_writeback_lsu #(.REGISTER_WIDTH(64), .REGISTER_DEPTH(32), .LOAD_TIMEOUT(TO)) dut64 (
    .clk(clk), .rst(rst64), .axis_memory_to_writeback(ax64), .flush(fl64),
    .mem_rvalid(rv64), .mem_rdata(rdat64), .registerport_write(rf64),
    .wb_valid(wbv64), .wb_rd(wbr64), .wb_data(wbd64),
    .misaligned_load(mis64), .load_timeout(to64), .instret(ir64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] bt,
                       input logic fl);
    if (w == 32) begin
      ax32.tvalid = v; ax32.opcode = op; ax32.funct3 = f3; ax32.rd = rd;
      ax32.alu_result = alu[31:0]; ax32.branch_target = bt[31:0]; fl32 = fl;
    end else begin
      ax64.tvalid = v; ax64.opcode = op; ax64.funct3 = f3; ax64.rd = rd;
      ax64.alu_result = alu; ax64.branch_target = bt; fl64 = fl;
    end
  endtask

  task automatic mem(input int w, input logic v, input logic [63:0] d);
    if (w == 32) begin rv32 = v; rdat32 = d[31:0]; end
    else begin rv64 = v; rdat64 = d; end
  endtask

  task automatic outs(input int w, output logic en, output logic [4:0] ad, output logic [63:0] dt,
                      output logic wv, output logic [4:0] wr, output logic [63:0] wd,
                      output logic mis, output logic to, output logic [63:0] ir, output logic rdy);
    if (w == 32) begin
      en = rf32.enable; ad = rf32.address; dt = {32'h0, rf32.data}; wv = wbv32; wr = wbr32;
      wd = {32'h0, wbd32}; mis = mis32; to = to32; ir = ir32; rdy = ax32.tready;
    end else begin
      en = rf64.enable; ad = rf64.address; dt = rf64.data; wv = wbv64; wr = wbr64;
      wd = wbd64; mis = mis64; to = to64; ir = ir64; rdy = ax64.tready;
    end
  endtask

  task automatic expect_out(input int w, input string tag, input logic en, input logic [4:0] rd,
                            input logic [63:0] data, input logic mis, input logic to,
                            input logic rdy);
    logic en_o, wv_o, mis_o, to_o, rdy_o;
    logic [4:0] ad_o, wr_o;
    logic [63:0] dt_o, wd_o, ir_o;
    outs(w, en_o, ad_o, dt_o, wv_o, wr_o, wd_o, mis_o, to_o, ir_o, rdy_o);
    chk({tag, ".enable"}, 64'(en_o), 64'(en));
    chk({tag, ".wb_valid"}, 64'(wv_o), 64'(en));
    if (en) begin
      chk({tag, ".address"}, 64'(ad_o), 64'(rd));
      chk({tag, ".data"}, dt_o, data);
      chk({tag, ".wb_rd"}, 64'(wr_o), 64'(rd));
      chk({tag, ".wb_data"}, wd_o, data);
    end
    chk({tag, ".misaligned"}, 64'(mis_o), 64'(mis));
    chk({tag, ".timeout"}, 64'(to_o), 64'(to));
    chk({tag, ".instret"}, ir_o, icnt[(w == 64) ? 1 : 0]);
    chk({tag, ".tready"}, 64'(rdy_o), 64'(rdy));
  endtask

  // Reference: what the instruction writes, from the architectural rules.
  function automatic void ref_wb(input int w, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [4:0] rd, input logic [63:0] alu,
                                 input logic [63:0] bt, input logic [63:0] rdata,
                                 output logic is_load, output logic mis, output logic we,
                                 output logic [63:0] data);
    logic [63:0] wmask, v, m;
    int nbytes, off, size;
    logic sgn, wr;
    wmask   = (w == 32) ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    nbytes  = w / 8;
    off     = int'(alu[5:0]) % nbytes;
    size    = 1 << f3[1:0];
    sgn     = !f3[2];
    is_load = (op == OP_LOAD);
    mis     = is_load && ((off % size) != 0);
    v       = (rdata & wmask) >> (off * 8);
    m       = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (size * 8)) - 64'd1);
    v       = v & m;
    if (sgn && size < 8 && v[size*8-1]) v = v | ~m;
    wr   = 1'b1;
    data = '0;
    case (op)
      OP_ARITH, OP_ARITH_IMM, OP_JALR: data = alu;
      OP_JAL:  data = bt;
      OP_LOAD: begin data = v; wr = !mis; end
      default: wr = 1'b0;
    endcase
    data = data & wmask;
    we   = wr && (rd != 5'd0);
  endfunction

  // Issue one instruction; loads get their response dly cycles late (0 = same cycle).
  task automatic do_instr(input int w, input string tag, input logic [6:0] op,
                          input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                          input logic [63:0] bt, input logic [63:0] rdata, input int dly);
    logic is_load, mis, we;
    logic [63:0] data;
    logic en_o, wv_o, mis_o, to_o, rdy_o;
    logic [4:0] ad_o, wr_o;
    logic [63:0] dt_o, wd_o, ir_o;
    ref_wb(w, op, f3, rd, alu, bt, rdata, is_load, mis, we, data);
    drive(w, 1'b1, op, f3, rd, alu, bt, 1'b0);
    mem(w, is_load && (dly == 0), rdata);
    step();
    drive(w, 1'b0, op, f3, rd, alu, bt, 1'b0);
    mem(w, 1'b0, rdata);
    if (is_load && !mis) begin
      for (int k = 1; k <= dly; k++) begin
        outs(w, en_o, ad_o, dt_o, wv_o, wr_o, wd_o, mis_o, to_o, ir_o, rdy_o);
        chk({tag, ".wait_tready"}, 64'(rdy_o), 64'd0);
        chk({tag, ".wait_enable"}, 64'(en_o), 64'd0);
        if (k == dly) mem(w, 1'b1, rdata);
        step();
        mem(w, 1'b0, rdata);
      end
    end
    if (!mis) icnt[(w == 64) ? 1 : 0]++;
    expect_out(w, tag, we, rd, data, mis, 1'b0, 1'b1);
  endtask

  task automatic run_random(input int w, input int n);
    logic [6:0] ops [7];
    logic [2:0] f3s32 [5];
    logic [2:0] f3, f3v;
    logic [6:0] op;
    ops   = '{OP_ARITH, OP_ARITH_IMM, OP_JALR, OP_JAL, OP_LOAD, OP_STORE, OP_BRANCH};
    f3s32 = '{F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    for (int i = 0; i < n; i++) begin
      op  = ops[$urandom_range(0, 6)];
      f3v = 3'($urandom_range(0, 6));
      f3  = (w == 32) ? f3s32[$urandom_range(0, 4)] : f3v;
      // Bias towards loads so alignment/latency paths see plenty of traffic.
      if ($urandom_range(0, 2) == 0) op = OP_LOAD;
      do_instr(w, "rnd", op, f3, 5'($urandom_range(0, 31)), {$urandom, $urandom},
               {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        step();
        expect_out(w, "rnd_gap", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    logic en_o, wv_o, mis_o, to_o, rdy_o;
    logic [4:0] ad_o, wr_o;
    logic [63:0] dt_o, wd_o, ir_o;

    icnt[0] = '0; icnt[1] = '0;
    rst32 = 1'b1; rst64 = 1'b1;
    drive(32, 1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0, 1'b0);
    drive(64, 1'b0, 7'd0, 3'd0, 5'd0, 64'd0, 64'd0, 1'b0);
    mem(32, 1'b0, 64'd0); mem(64, 1'b0, 64'd0);
    #1 rst32 = 1'b0; rst64 = 1'b0;
    #2;
    expect_out(32, "reset32", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    expect_out(64, "reset64", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    step();
    rst32 = 1'b1; rst64 = 1'b1;
    step();

    // ADDI rd=5 -> one-cycle write of 7
    do_instr(32, "addi", OP_ARITH_IMM, 3'd0, 5'd5, 64'd7, 64'd0, 64'd0, 0);
    step();
    expect_out(32, "addi_pulse", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // LB offset 3, response 4 cycles late
    do_instr(32, "lb_late", OP_LOAD, F3_LB, 5'd6, 64'd3, 64'd0, 64'h80FF_FFFF, 4);
    step();
    expect_out(32, "lb_once", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // LH offset 1 is misaligned
    do_instr(32, "lh_mis", OP_LOAD, F3_LH, 5'd7, 64'd1, 64'd0, 64'd0, 0);
    step();
    expect_out(32, "lh_mis_pulse", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // Stray response while idle is ignored
    mem(32, 1'b1, 64'h1234_5678);
    step();
    mem(32, 1'b0, 64'd0);
    expect_out(32, "stray_rvalid", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // LW with no response -> timeout after TO wait cycles
    drive(32, 1'b1, OP_LOAD, F3_LW, 5'd9, 64'd8, 64'd0, 1'b0);
    step();
    drive(32, 1'b0, OP_LOAD, F3_LW, 5'd9, 64'd8, 64'd0, 1'b0);
    for (int k = 1; k <= TO; k++) begin
      outs(32, en_o, ad_o, dt_o, wv_o, wr_o, wd_o, mis_o, to_o, ir_o, rdy_o);
      chk("timeout.wait_tready", 64'(rdy_o), 64'd0);
      step();
    end
    expect_out(32, "timeout", 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    step();
    expect_out(32, "timeout_pulse", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // Pending load; flush together with the response
    drive(32, 1'b1, OP_LOAD, F3_LW, 5'd3, 64'd0, 64'd0, 1'b0);
    step();
    drive(32, 1'b0, OP_LOAD, F3_LW, 5'd3, 64'd0, 64'd0, 1'b0);
    step();
    fl32 = 1'b1;
    mem(32, 1'b1, 64'hCAFE_F00D);
    step();
    fl32 = 1'b0;
    mem(32, 1'b0, 64'd0);
    expect_out(32, "flush_rvalid", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    step();
    expect_out(32, "flush_after", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // Flush in the accept cycle discards the beat
    drive(32, 1'b1, OP_ARITH, 3'd0, 5'd4, 64'h55, 64'd0, 1'b1);
    step();
    drive(32, 1'b0, OP_ARITH, 3'd0, 5'd4, 64'h55, 64'd0, 1'b0);
    expect_out(32, "flush_accept", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a load wait
    drive(32, 1'b1, OP_LOAD, F3_LW, 5'd3, 64'd0, 64'd0, 1'b0);
    step();
    drive(32, 1'b0, OP_LOAD, F3_LW, 5'd3, 64'd0, 64'd0, 1'b0);
    step();
    outs(32, en_o, ad_o, dt_o, wv_o, wr_o, wd_o, mis_o, to_o, ir_o, rdy_o);
    chk("pre_rst.tready", 64'(rdy_o), 64'd0);
    #2 rst32 = 1'b0;
    #1;
    icnt[0] = '0;
    expect_out(32, "async_rst", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    #2 rst32 = 1'b1;
    step();
    expect_out(32, "post_rst", 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b1);

    run_random(32, 40);

    // 64-bit: LWU offset 4, JAL to x0, LD, LW sign extension
    do_instr(64, "lwu64", OP_LOAD, F3_LWU, 5'd7, 64'h1004, 64'd0, 64'h8765_4321_DEAD_BEEF, 0);
    do_instr(64, "jal_x0", OP_JAL, 3'd0, 5'd0, 64'd0, 64'h4000, 64'd0, 0);
    do_instr(64, "ld64", OP_LOAD, F3_LD, 5'd8, 64'h2000, 64'd0, 64'hFEDC_BA98_7654_3210, 2);
    do_instr(64, "lw64", OP_LOAD, F3_LW, 5'd9, 64'h4, 64'd0, 64'h8000_0001_0000_0000, 1);
    do_instr(64, "ld_mis", OP_LOAD, F3_LD, 5'd10, 64'h4, 64'd0, 64'd0, 0);
    run_random(64, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stage5_writeback_lsu
`default_nettype wire
